// File: rtl/mem_port_arbiter_pkg.sv
// Package mem_arb_pkg: shared types and constants for mem_port_arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   PORT_IF     : port index of instruction fetch (0)
//   PORT_LS     : port index of load/store (1)
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Interface mem_port_arbiter_if: requester handshakes and memory port bundle.
//   req0/req1, addr0/addr1, wdata0/wdata1, we0/we1 : requester side inputs
//   gnt0/gnt1, done0/done1, rdata                  : requester side outputs
//   mem_req, mem_addr, mem_wdata, mem_we           : memory port outputs
//   mem_ready, mem_rdata                           : memory port inputs
// Modports: slave  = arbiter view
//           master = requesters + memory (environment) view
interface mem_port_arbiter_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] addr0;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic             we0;
  logic             we1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] rdata;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
    input  mem_ready, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata,
    output mem_req, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1,
    output mem_ready, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata,
    input  mem_req, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_port_arbiter_mux2.sv
// mux2: plain 2:1 multiplexer used to steer requester fields onto the memory port.
//   i_sel : 0 selects i_a, 1 selects i_b
//   i_a   : input for select 0 (WIDTH)
//   i_b   : input for select 1 (WIDTH)
//   o_y   : selected output (WIDTH)
module mux2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (port 0)
// and load/store (port 1). The grant is held for the whole memory transaction;
// the winner's address, write data and write enable are steered onto the
// memory port through 2:1 muxes driven by the registered select.
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : mem_port_arbiter_if.slave (requester handshakes + memory port)
// Build option: define ARB_FIXED_PRIO_EN to make port 1 win every tie;
// otherwise ties are resolved round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_sel;
  logic       w_sel_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic       r_gnt0;
  logic       w_gnt0_nxt;
  logic       r_gnt1;
  logic       w_gnt1_nxt;
  logic       w_win;
  logic       w_busy;
  logic       w_mux_sel;

  // Winner for a new transaction; a lone requester always wins.
  always_comb begin
    w_win = PORT_IF;
    if (bus.req0 && bus.req1) begin
`ifdef ARB_FIXED_PRIO_EN
      w_win = PORT_LS;
`else
      w_win = ~r_last;
`endif
    end else if (bus.req1) begin
      w_win = PORT_LS;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_gnt0_nxt  = r_gnt0;
    w_gnt1_nxt  = r_gnt1;
    unique case (r_state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_state_nxt = BUSY;
          w_sel_nxt   = w_win;
          w_last_nxt  = w_win;
          w_gnt0_nxt  = (w_win == PORT_IF);
          w_gnt1_nxt  = (w_win == PORT_LS);
        end
      end
      BUSY: begin
        // Requesters dropping req here are ignored: only memory completion ends BUSY.
        if (bus.mem_ready) begin
          w_state_nxt = IDLE;
          w_gnt0_nxt  = 1'b0;
          w_gnt1_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sel   <= PORT_IF;
      r_last  <= PORT_LS;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
    end
  end

  assign w_busy    = (r_state == BUSY);
  // Outside BUSY the memory fields fall back to the port 0 path.
  assign w_mux_sel = w_busy & r_sel;

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.mem_req = w_busy;
  assign bus.done0   = w_busy & (r_sel == PORT_IF) & bus.mem_ready;
  assign bus.done1   = w_busy & (r_sel == PORT_LS) & bus.mem_ready;
  assign bus.rdata   = bus.mem_rdata;

  mux2 #(.WIDTH(WIDTH)) u_mux_addr (
    .i_sel (w_mux_sel),
    .i_a   (bus.addr0),
    .i_b   (bus.addr1),
    .o_y   (bus.mem_addr)
  );

  mux2 #(.WIDTH(WIDTH)) u_mux_wdata (
    .i_sel (w_mux_sel),
    .i_a   (bus.wdata0),
    .i_b   (bus.wdata1),
    .o_y   (bus.mem_wdata)
  );

  mux2 #(.WIDTH(1)) u_mux_we (
    .i_sel (w_mux_sel),
    .i_a   (bus.we0),
    .i_b   (bus.we1),
    .o_y   (bus.mem_we)
  );

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the core's single memory port between instruction fetch (port 0) and load/store (port 1). It runs a request/grant/done handshake with each requester and holds the grant for the whole memory transaction, however long the memory stalls. It steers the winner's address, write data and write enable onto the memory port through a registered select driving 2:1 muxes.

## Interface
- `WIDTH`, 32: address and data width.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `req0`, `req1`  in  1 each: requester wants a transaction; held high with fields stable until its `done`.
- `addr0`, `addr1`  in  WIDTH each: requester address.
- `wdata0`, `wdata1`  in  WIDTH each: requester write data.
- `we0`, `we1`  in  1 each: requester write enable.
- `gnt0`, `gnt1`  out  1 each: registered; high for the whole duration of the requester's transaction.
- `done0`, `done1`  out  1 each: one-cycle completion strobe to the requester.
- `rdata`  out  WIDTH: read data, broadcast to both requesters; valid when `done` is high.
- `mem_req`  out  1: memory transaction active.
- `mem_addr`, `mem_wdata`  out  WIDTH: muxed from the selected requester.
- `mem_we`  out  1: muxed from the selected requester.
- `mem_ready`  in  1: memory completes the transaction this cycle.
- `mem_rdata`  in  WIDTH: memory read data.

## Operation
- FSM states:
  - IDLE: `mem_req`=0, no grant.
  - BUSY: `mem_req`=1, exactly one grant high.
- IDLE -> BUSY when `req0|req1`:
  - Winner latched into `sel`; `gnt[sel]` set; `last` updated to `sel`.
  - Arbitration when both request: round-robin. The port not equal to `last` wins.
  - Single requester: that requester wins regardless of `last`.
- BUSY -> IDLE when `mem_ready`=1; `gnt` cleared.
- BUSY with `mem_ready`=0: stay in BUSY, all registers hold.
- Done strobes (combinational): `done_i = (state==BUSY) & (sel==i) & mem_ready`.
- `rdata = mem_rdata` (pass-through).
- Memory fields:
  - `mem_addr`/`mem_wdata`/`mem_we` = selected requester's fields when `sel`=1 selects port 1, else port 0.
  - In IDLE these outputs are don't-care but still driven by the port 0 mux path.
- Requester dropping `req` while granted: ignored, transaction runs to completion; the `done` strobe still fires.
- A new request arriving in BUSY waits. It is arbitrated in the next IDLE cycle, so there is one bubble cycle between back-to-back transactions.
- Reset (`reset_n`=0 at an edge), including in the middle of a transaction:
  - state=IDLE, `sel`=0, `gnt0`=`gnt1`=0, `mem_req`=0, `last`=1 (so port 0 wins the first tie).
  - `done0`/`done1`=0.
  - An in-flight memory access is abandoned; the requester must reissue.

## Timing
- Request high in IDLE at edge N -> `gnt`/`mem_req` high after edge N (cycle N+1).
- `mem_ready` high in cycle M -> `done` high in cycle M, combinationally.
- Grant drops after edge M.
- Minimum transaction with `mem_ready` already high on the first BUSY cycle: 2 cycles from request to done.
- Minimum issue interval per port: 2 cycles (BUSY + IDLE).
- Worst-case wait under contention: one full transaction of the other port plus the IDLE bubble.

## Configuration
- `ARB_FIXED_PRIO_EN`:
  - Defined: port 1 (data) always wins ties; `last` is not used for arbitration.
  - Undefined: round-robin as above.
- Single-request behaviour is identical either way.

## Structure
- Shared package `mem_arb_pkg`:
  - State enum: IDLE, BUSY.
  - Port index localparams: `PORT_IF`=0, `PORT_LS`=1.
- One sub-module: `mux2` parameterised by `WIDTH`, used three times:
  - address, WIDTH wide;
  - write data, WIDTH wide;
  - write enable, width 1.
- The FSM, `sel` and `last` are kept in the top module.

## Test plan
- Reset: hold `reset_n`=0 with `req0`=`req1`=1 -> `mem_req`=0, `gnt`=00, `done`=00; release -> port 0 granted next cycle, `mem_addr`=`addr0`.
- Single port-1 read:
  - Stimulus: `addr1`=32'h0000_1000, `we1`=0, `mem_ready` high 3 cycles after grant with `mem_rdata`=32'hA5A5A5A5.
  - Response: `gnt1` held 4 cycles, `done1` pulses once, `rdata`=32'hA5A5A5A5.
- Round-robin: both request continuously, `mem_ready` always 1 -> grants alternate 0,1,0,1 with one IDLE bubble between; with `ARB_FIXED_PRIO_EN` -> port 1 granted every transaction.
- Port 0 write:
  - Stimulus: `addr0`=32'h10, `wdata0`=32'h5A5A5A5A, `we0`=1.
  - Response: `mem_we`=1 and `mem_wdata`=32'h5A5A5A5A for the whole BUSY period; unselected port fields never appear on the memory port.
- Requester drop: `req0` falls mid-stall -> `gnt0` stays, `done0` still pulses on `mem_ready`, then IDLE.
- Reset mid-transaction: `reset_n`=0 during BUSY with `mem_ready`=0 -> next cycle IDLE, `mem_req`=0, no `done`; the next tie goes to port 0.
